// File: rtl/pug_mdu_ctl.sv
// Issue-side controller for an RV32M multiply/divide unit.
// Accepts one instruction at a time, clears the unit, starts it, waits for
// completion (with a watchdog) and presents a single result for transfer.
//
// Handshake rule for both in_* and out_* ports: a transfer happens on a rising
// clk edge where valid and ready are both high; valid never waits on ready, and
// the payload is held stable while valid is high and ready is low.
module pug_mdu_ctl #(
    parameter int unsigned TMO = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        md_go,
    output logic        md_rst,
    output logic [2:0]  md_fn3,
    output logic [31:0] md_rs1,
    output logic [31:0] md_rs2,
    input  logic        md_done,
    input  logic [31:0] md_rd,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        GO   = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    // Last WAIT cycle index before the watchdog fires (WAIT lasts TMO cycles).
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        md_rst_nx;
    logic [2:0]  fn3_nx;
    logic [31:0] rs1_nx, rs2_nx;
    logic [4:0]  rd_nx;
    logic [31:0] data_nx;
    logic        err_nx;
    logic        is_m;

    // Only OP-opcode instructions with the MULDIV funct7 go to the unit.
    assign is_m = (in_insn[6:0] == 7'b0110011) && (in_insn[31:25] == 7'b0000001);

    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state == RESP);
    assign md_go     = (state == GO);
    assign dbg_state = state;

    // Next-state, payload capture, watchdog and unit-reset strobe.
    always_comb begin
        state_nx  = state;
        cnt_nx    = '0;
        md_rst_nx = 1'b0;
        fn3_nx    = md_fn3;
        rs1_nx    = md_rs1;
        rs2_nx    = md_rs2;
        rd_nx     = out_rd;
        data_nx   = out_data;
        err_nx    = out_err;
        if (flush) begin
            // Abort wins over everything; reset the unit so it forgets the op.
            state_nx  = IDLE;
            md_rst_nx = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        fn3_nx = in_insn[14:12];
                        rs1_nx = in_rs1;
                        rs2_nx = in_rs2;
                        rd_nx  = in_insn[11:7];
                        if (is_m) begin
                            state_nx  = CLR;
                            md_rst_nx = 1'b1;
                        end else begin
                            state_nx = RESP;
                            err_nx   = 1'b1;
                            data_nx  = '0;
                        end
                    end
                end
                CLR:  state_nx = GO;
                GO:   state_nx = WAIT;
                WAIT: begin
                    if (md_done) begin
                        state_nx = RESP;
                        err_nx   = 1'b0;
                        data_nx  = (out_rd == 5'd0) ? 32'd0 : md_rd;
                    end else if (cnt == TMO_LAST) begin
                        // Unit hung: report an error and reset it.
                        state_nx  = RESP;
                        err_nx    = 1'b1;
                        data_nx   = 32'hFFFF_FFFF;
                        md_rst_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (out_ready) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, counter and registered outputs; md_rst is held high through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            md_rst   <= 1'b1;
            md_fn3   <= '0;
            md_rs1   <= '0;
            md_rs2   <= '0;
            out_rd   <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            md_rst   <= md_rst_nx;
            md_fn3   <= fn3_nx;
            md_rs1   <= rs1_nx;
            md_rs2   <= rs2_nx;
            out_rd   <= rd_nx;
            out_data <= data_nx;
            out_err  <= err_nx;
        end
    end

endmodule

// File: tb/tb_pug_mdu_ctl.sv
// Bench for pug_mdu_ctl: emulated RV32M unit, transaction-level reference model,
// per-cycle comparison process and directed scenarios with literal results.
module tb_pug_mdu_ctl;

    localparam int TMO = 63;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_insn = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_err;
    logic        md_go;
    logic        md_rst;
    logic [2:0]  md_fn3;
    logic [31:0] md_rs1;
    logic [31:0] md_rs2;
    logic        md_done = 1'b0;
    logic [31:0] md_rd = '0;
    logic [2:0]  dbg_state;

    pug_mdu_ctl #(.TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_err(out_err),
        .md_go(md_go), .md_rst(md_rst),
        .md_fn3(md_fn3), .md_rs1(md_rs1), .md_rs2(md_rs2),
        .md_done(md_done), .md_rd(md_rd), .dbg_state(dbg_state)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // RV32M arithmetic straight from the ISA definition.
    function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, zb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        zb = longint'({32'b0, b});
        p = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * zb); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- emulated multiply/divide unit ----------------
    int   u_lat = 3;
    logic u_tie = 1'b0;
    int   u_cnt = 0;
    always @(posedge clk) begin
        if (md_rst) begin
            md_done <= 1'b0;
            u_cnt   <= 0;
        end else if (md_go) begin
            u_cnt <= u_lat;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1 && !u_tie) begin
                md_done <= 1'b1;
                md_rd   <= rv32m(md_fn3, md_rs1, md_rs2);
            end
        end
    end

    // ---------------- reference model ----------------
    // e_* are the outputs expected in the current cycle; e_age counts cycles
    // since the accept edge (1 = first cycle after it) while an op is in flight.
    logic        e_idle = 1'b1, e_valid = 1'b0, e_go = 1'b0, e_mrst = 1'b1, e_err = 1'b0;
    logic [4:0]  e_rd = '0;
    logic [2:0]  e_fn3 = '0;
    logic [31:0] e_data = '0, e_rs1 = '0, e_rs2 = '0;
    int          e_age = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_idle <= 1'b1; e_valid <= 1'b0; e_go <= 1'b0; e_mrst <= 1'b1; e_err <= 1'b0;
            e_rd <= '0; e_fn3 <= '0; e_data <= '0; e_rs1 <= '0; e_rs2 <= '0; e_age <= 0;
        end else if (flush) begin
            e_idle <= 1'b1; e_valid <= 1'b0; e_go <= 1'b0; e_mrst <= 1'b1; e_age <= 0;
        end else if (e_idle) begin
            e_mrst <= 1'b0; e_go <= 1'b0;
            if (in_valid) begin
                e_idle <= 1'b0;
                e_fn3 <= in_insn[14:12]; e_rs1 <= in_rs1; e_rs2 <= in_rs2; e_rd <= in_insn[11:7];
                if (in_insn[6:0] == 7'h33 && in_insn[31:25] == 7'h01) begin
                    e_age <= 1; e_mrst <= 1'b1;
                end else begin
                    e_valid <= 1'b1; e_err <= 1'b1; e_data <= '0;
                end
            end
        end else if (e_valid) begin
            e_mrst <= 1'b0; e_go <= 1'b0;
            if (out_ready) begin e_valid <= 1'b0; e_idle <= 1'b1; e_age <= 0; end
        end else begin
            e_mrst <= 1'b0;
            e_go <= (e_age == 1);
            if (e_age < 3) e_age <= e_age + 1;
            else if (md_done) begin
                e_valid <= 1'b1; e_err <= 1'b0;
                e_data <= (e_rd == 0) ? 32'd0 : rv32m(e_fn3, e_rs1, e_rs2);
            end else if (e_age - 3 == TMO - 1) begin
                e_valid <= 1'b1; e_err <= 1'b1; e_data <= 32'hFFFF_FFFF; e_mrst <= 1'b1;
            end else e_age <= e_age + 1;
        end
    end

    // ---------------- per-cycle comparison (scoreboard) ----------------
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(e_idle && !flush));
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("md_go", 32'(md_go), 32'(e_go));
        check("md_rst", 32'(md_rst), 32'(e_mrst));
        if (e_valid || !rst_n) begin
            check("out_rd", 32'(out_rd), 32'(e_rd));
            check("out_data", out_data, e_data);
            check("out_err", 32'(out_err), 32'(e_err));
        end
        if (!e_idle || !rst_n) begin
            check("md_fn3", 32'(md_fn3), 32'(e_fn3));
            check("md_rs1", md_rs1, e_rs1);
            check("md_rs2", md_rs2, e_rs2);
        end
    end

    // ---------------- strobe monitor ----------------
    int go_cnt = 0, rst_cnt = 0, valid_cnt = 0, go_first = -1, rst_first = -1;
    always @(negedge clk) begin
        if (md_go) begin go_cnt++; if (go_first < 0) go_first = cyc; end
        if (md_rst) begin rst_cnt++; if (rst_first < 0) rst_first = cyc; end
        if (out_valid) valid_cnt++;
    end

    // ---------------- driver tasks ----------------
    int acc_edge = 0;
    int resp_cyc = 0;

    task automatic clear_mon();
        go_cnt = 0; rst_cnt = 0; valid_cnt = 0; go_first = -1; rst_first = -1;
    endtask

    // Present one instruction and hold it until accepted (bounded).
    task automatic send(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(posedge clk); #1;
        clear_mon();
        in_valid = 1'b1; in_insn = insn; in_rs1 = a; in_rs2 = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        check("send_accept", 32'(in_ready), 32'd1);
        acc_edge = cyc + 1;  // cycle "k+1" is the one that begins at accept edge k
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, compare literals, optionally stall it.
    task automatic wait_resp(input string tag, input logic [4:0] rd, input logic [31:0] data,
                             input logic err, input int hold);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin n++; @(negedge clk); end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        resp_cyc = cyc;
        check({tag, "_rd"}, 32'(out_rd), 32'(rd));
        check({tag, "_data"}, out_data, data);
        check({tag, "_err"}, 32'(out_err), 32'(err));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "_held_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_held_data"}, out_data, data);
            check({tag, "_held_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_go();
        int n = 0;
        @(negedge clk);
        while (go_first < 0 && n < 20) begin n++; @(negedge clk); end
        check("wait_go", 32'(go_first >= 0), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_MUL0  = 32'h02208033;
    localparam logic [31:0] I_DIV   = 32'h0220C1B3;
    localparam logic [31:0] I_REMU  = 32'h0220F1B3;
    localparam logic [31:0] I_ADD   = 32'h002081B3;

    initial begin
        int g;
        // reset values
        repeat (3) @(negedge clk);
        check("rst_md_rst", 32'(md_rst), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_md_rs1", md_rs1, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rel_md_rst", 32'(md_rst), 32'd0);

        // MUL x3 = 7*6 with latency check
        send(I_MUL, 32'd7, 32'd6);
        wait_resp("mul", 5'd3, 32'd42, 1'b0, 0);
        check("mul_rst_cycle", 32'(rst_first), 32'(acc_edge));
        check("mul_go_cycle", 32'(go_first), 32'(acc_edge + 1));
        check("mul_go_cnt", 32'(go_cnt), 32'd1);

        // DIV by zero and signed overflow pass-through
        send(I_DIV, 32'd5, 32'd0);
        wait_resp("div0", 5'd3, 32'hFFFF_FFFF, 1'b0, 0);
        check("div0_rst_before_go", 32'(rst_first + 1), 32'(go_first));
        check("div0_rst_cnt", 32'(rst_cnt), 32'd1);
        send(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_resp("divov", 5'd3, 32'h8000_0000, 1'b0, 0);
        check("divov_rst_before_go", 32'(rst_first + 1), 32'(go_first));
        check("divov_rst_cnt", 32'(rst_cnt), 32'd1);

        // REMU with result stalled for 10 cycles
        out_ready = 1'b0;
        send(I_REMU, 32'd100, 32'd7);
        wait_resp("remu", 5'd3, 32'd2, 1'b0, 10);
        check("remu_go_cnt", 32'(go_cnt), 32'd1);

        // Non-M instruction -> immediate error response
        send(I_ADD, 32'd1, 32'd2);
        wait_resp("add", 5'd3, 32'd0, 1'b1, 0);
        check("add_go_cnt", 32'(go_cnt), 32'd0);
        check("add_rst_cnt", 32'(rst_cnt), 32'd0);

        // Destination x0 forces data to zero
        send(I_MUL0, 32'd7, 32'd6);
        wait_resp("mulx0", 5'd0, 32'd0, 1'b0, 0);

        // Flush in WAIT five cycles after md_go
        u_lat = 20;
        send(I_MUL, 32'd7, 32'd6);
        wait_go();
        g = go_first;
        while (cyc < g + 4) @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1; rst_cnt = 0; valid_cnt = 0;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_rst_cnt", 32'(rst_cnt), 32'd1);
        check("flush_no_valid", 32'(valid_cnt), 32'd0);
        check("flush_idle", 32'(in_ready), 32'd1);
        u_lat = 3;
        send(I_MUL, 32'd3, 32'd3);
        wait_resp("mul33", 5'd3, 32'd9, 1'b0, 0);

        // Flush together with in_valid in IDLE: nothing accepted
        @(posedge clk); #1;
        clear_mon();
        flush = 1'b1; in_valid = 1'b1; in_insn = I_MUL;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("flushacc_go_cnt", 32'(go_cnt), 32'd0);
        check("flushacc_rst_cnt", 32'(rst_cnt), 32'd1);

        // Watchdog: unit never completes
        u_tie = 1'b1;
        send(I_MUL, 32'd7, 32'd6);
        wait_resp("tmo", 5'd3, 32'hFFFF_FFFF, 1'b1, 0);
        check("tmo_cycle", 32'(resp_cyc), 32'(go_first + TMO + 1));

        // Reset pulsed mid-WAIT
        send(I_MUL, 32'd7, 32'd6);
        wait_go();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_md_rst", 32'(md_rst), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_md_go", 32'(md_go), 32'd0);
        check("midrst_md_fn3", 32'(md_fn3), 32'd0);
        check("midrst_out_rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        u_tie = 1'b0;
        valid_cnt = 0;
        repeat (8) @(negedge clk);
        check("midrst_no_valid", 32'(valid_cnt), 32'd0);

        // Back to normal after reset
        send(I_MUL, 32'd12, 32'd11);
        wait_resp("mul_after", 5'd3, 32'd132, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pug_mdu_ctl.md
PUG_MDU_CTL -- requirements
Module: pug_mdu_ctl

Interface
REQ-001 Parameter: TMO, default 63, WAIT-state watchdog limit in cycles (legal range 40..255).
REQ-002 Port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: flush  in  1  synchronous abort of any operation in progress.
REQ-005 Port: in_valid / in_ready  in / out  1 / 1  instruction handshake; transfer when both are high.
REQ-006 Port: in_insn / in_rs1 / in_rs2  in  32 each  instruction word and the two operand values.
REQ-007 Port: out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-008 Port: out_rd / out_data / out_err  out  5 / 32 / 1  destination index, result value, error flag.
REQ-009 Port: md_go / md_rst  out  1 / 1  start and reset strobes to the RV32M multiply/divide unit.
REQ-010 Port: md_fn3 / md_rs1 / md_rs2  out  3 / 32 / 32  operation select and operands to the unit.
REQ-011 Port: md_done / md_rd  in  1 / 32  completion flag (sticky until md_rst) and result from the unit.

Function
REQ-012 States SHALL be IDLE, CLR, GO, WAIT and RESP.
REQ-013 in_ready SHALL equal (state==IDLE && !flush).
REQ-014 On an accept, the block SHALL latch insn[14:12] into md_fn3, the operands into md_rs1/md_rs2, and insn[11:7] into out_rd.
- Legal M instruction (insn[6:0]==0110011 and insn[31:25]==0000001): next state CLR.
- Anything else: next state RESP with out_err=1 and out_data=0.
REQ-015 CLR SHALL hold md_rst=1 for exactly one cycle, then go to GO; this clears the unit's sticky done and div0/overflow flags.
REQ-016 GO SHALL hold md_go=1 for exactly one cycle, then go to WAIT.
REQ-017 md_fn3, md_rs1 and md_rs2 SHALL stay stable from the accept until the next return to IDLE, because the unit samples them again at completion.
REQ-018 In WAIT, on md_done=1 the block SHALL capture md_rd into out_data (forced to 0 when out_rd==0), set out_err=0 and go to RESP.
REQ-019 A WAIT cycle counter SHALL start at 0 on entry. If it reaches TMO without md_done, the block SHALL go to RESP with out_err=1 and out_data=32'hFFFFFFFF, and pulse md_rst for one cycle.
REQ-020 In RESP, out_valid SHALL be 1. out_rd, out_data and out_err SHALL be held stable while out_ready=0.
REQ-021 In RESP with out_ready=1, the block SHALL return to IDLE and drop out_valid next cycle. There is no same-cycle re-accept, so throughput is at most one operation per 5+unit-latency cycles.
REQ-022 Latency SHALL be: accept at edge k, md_rst high in cycle k+1, md_go high in cycle k+2, out_valid one cycle after the edge where md_done is sampled high.
REQ-023 flush=1 in any state SHALL, at the next edge: set state to IDLE, out_valid=0, md_go=0, md_rst=1 for one cycle. It overrides every other event, including in_valid and out_ready in the same cycle.
REQ-024 md_go and md_rst SHALL never be high in the same cycle.
REQ-025 md_go SHALL be high at most once per accepted instruction.
REQ-026 Division-by-zero and signed-overflow results SHALL be passed through from md_rd unchanged; the block does not special-case them.

Reset
REQ-027 While rst_n=0, the block SHALL be in state IDLE with out_valid=0, out_rd=0, out_data=0, out_err=0, md_go=0, md_fn3=0, md_rs1=0, md_rs2=0 and counter=0.
REQ-028 md_rst SHALL be 1 while rst_n=0 and for the first clock edge after release, then 0.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no output transfer.

Verification
REQ-030 MUL x3,x1,x2 (insn 0x022081B3), rs1=7, rs2=6 -> md_rst at k+1, md_go at k+2, then out_valid with out_rd=3, out_data=42, out_err=0.
REQ-031 DIV (0x0220C1B3): rs1=5, rs2=0 -> out_data=0xFFFFFFFF; then rs1=0x80000000, rs2=0xFFFFFFFF -> out_data=0x80000000. Each operation shows one md_rst pulse before md_go.
REQ-032 REMU (0x0220F1B3), rs1=100, rs2=7, out_ready held 0 for 10 cycles -> out_valid and out_data=2 stable throughout, in_ready=0, no second md_go.
REQ-033 ADD (0x002081B3) -> no md_go and no md_rst; RESP with out_err=1, out_data=0, out_rd=3.
REQ-034 flush asserted in WAIT 5 cycles after md_go -> IDLE next edge, one md_rst pulse, no out_valid; next MUL 3*3 -> out_data=9.
REQ-035 Tie md_done=0 -> after TMO WAIT cycles, out_err=1 and out_data=0xFFFFFFFF. Separately, rst_n pulsed low mid-WAIT -> all outputs at reset values and md_rst=1.
